// File: rtl/fp32_maxmin_seq_pkg.sv
// rtl/fp32_maxmin_seq_pkg.sv - shared constants, state encoding and FP32 helpers
package fp32_maxmin_seq_pkg;

   localparam int FP_W     = 32;
   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;

   localparam logic [2:0] OP_GTE = 3'd0;
   localparam logic [2:0] OP_GT  = 3'd1;
   localparam logic [2:0] OP_EQ  = 3'd2;
   localparam logic [2:0] OP_LT  = 3'd3;
   localparam logic [2:0] OP_LTE = 3'd4;

   localparam logic [FP_W-1:0] QNAN = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FIRST = 3'd1,
      ST_NEXT  = 3'd2,
      ST_CMP   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   function automatic logic is_nan(input logic [FP_W-1:0] x);
      return (x[FP_W-2 -: FP_EXP_W] == '1) && (x[FP_MAN_W-1:0] != '0);
   endfunction

   // Maps FP32 onto an unsigned key whose integer order is the float order (-0 sorts below +0).
   function automatic logic [FP_W-1:0] order_key(input logic [FP_W-1:0] x);
      return x[FP_W-1] ? ~x : {1'b1, x[FP_W-2:0]};
   endfunction

endpackage

// File: rtl/fp32_cmp.sv
// rtl/fp32_cmp.sv - registered FP32 comparator; result valid the cycle after i_valid
module fp32_cmp
   import fp32_maxmin_seq_pkg::*;
(
   input  logic            clk,
   input  logic            rstn,
   input  logic            i_valid,
   input  logic [FP_W-1:0] i_a,
   input  logic [FP_W-1:0] i_b,
   input  logic [2:0]      i_op,
   output logic            o_result,
   output logic            o_nan_err
);

   logic [FP_W-1:0] key_a;
   logic [FP_W-1:0] key_b;
   logic            res_d;
   logic            res_q;
   logic            nan_d;
   logic            nan_q;

   always_comb begin
      key_a = order_key(i_a);
      key_b = order_key(i_b);
      nan_d = is_nan(i_a) || is_nan(i_b);
      res_d = 1'b0;
      case (i_op)
         OP_GTE:  res_d = key_a >= key_b;
         OP_GT:   res_d = key_a >  key_b;
         OP_EQ:   res_d = key_a == key_b;
         OP_LT:   res_d = key_a <  key_b;
         OP_LTE:  res_d = key_a <= key_b;
         default: res_d = 1'b0;
      endcase
      if (nan_d) res_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         res_q <= 1'b0;
         nan_q <= 1'b0;
      end else if (i_valid) begin
         res_q <= res_d;
         nan_q <= nan_d;
      end
   end

   assign o_result  = res_q;
   assign o_nan_err = nan_q;

endmodule

// File: rtl/fp32_maxmin_seq.sv
// rtl/fp32_maxmin_seq.sv - streaming FP32 argmax/argmin reducer around one fp32_cmp
module fp32_maxmin_seq
   import fp32_maxmin_seq_pkg::*;
#(
   parameter int LEN_W = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_mode,
   input  logic [LEN_W-1:0] i_len,
   input  logic             i_valid,
   input  logic [31:0]      i_data,
   output logic             o_ready,
   output logic             o_busy,
   output logic             o_done,
   output logic [31:0]      o_result,
   output logic [LEN_W-1:0] o_index,
   output logic             o_nan_err
);

   state_t           state_q, state_d;
   logic             mode_q, mode_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [LEN_W-1:0] count_inc;
   logic [31:0]      acc_q, acc_d;
   logic [31:0]      elem_q, elem_d;
   logic             nan_q, nan_d;

   logic             cmp_rstn;
   logic             cmp_valid;
   logic [2:0]       cmp_op;
   logic             cmp_res;
   logic             cmp_nan;

   assign cmp_rstn  = ~rst;
   assign count_inc = count_q + LEN_W'(1);

   fp32_cmp u_cmp (
      .clk       (clk),
      .rstn      (cmp_rstn),
      .i_valid   (cmp_valid),
      .i_a       (i_data),
      .i_b       (acc_q),
      .i_op      (cmp_op),
      .o_result  (cmp_res),
      .o_nan_err (cmp_nan)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q  <= 1'b0;
         len_q   <= '0;
         count_q <= '0;
         idx_q   <= '0;
         acc_q   <= '0;
         elem_q  <= '0;
         nan_q   <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         len_q   <= len_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         elem_q  <= elem_d;
         nan_q   <= nan_d;
      end
   end

   // o_ready is a pure function of state, so i_valid alone marks a handshake in FIRST/NEXT.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      len_d     = len_q;
      count_d   = count_q;
      idx_d     = idx_q;
      acc_d     = acc_q;
      elem_d    = elem_q;
      nan_d     = nan_q;
      cmp_valid = 1'b0;
      cmp_op    = mode_q ? OP_LT : OP_GT;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               mode_d  = i_mode;
               len_d   = i_len;
               count_d = '0;
               idx_d   = '0;
               acc_d   = '0;
               nan_d   = 1'b0;
               state_d = (i_len == '0) ? ST_DONE : ST_FIRST;
            end
         end
         ST_FIRST: begin
            if (i_valid) begin
               acc_d   = i_data;
               idx_d   = '0;
               count_d = LEN_W'(1);
               if (is_nan(i_data)) nan_d = 1'b1;
               state_d = (len_q == LEN_W'(1)) ? ST_DONE : ST_NEXT;
            end
         end
         ST_NEXT: begin
            if (i_valid) begin
               cmp_valid = 1'b1;
               elem_d    = i_data;
               state_d   = ST_CMP;
            end
         end
         ST_CMP: begin
            if (cmp_nan) begin
               nan_d = 1'b1;
            end else if (cmp_res) begin
               acc_d = elem_q;
               idx_d = count_q;
            end
            count_d = count_inc;
            state_d = (count_inc == len_q) ? ST_DONE : ST_NEXT;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      o_ready   = (state_q == ST_FIRST) || (state_q == ST_NEXT);
      o_busy    = (state_q != ST_IDLE);
      o_done    = (state_q == ST_DONE);
      o_result  = nan_q ? QNAN : acc_q;
      o_index   = idx_q;
      o_nan_err = nan_q;
   end

endmodule

// File: tb/tb_fp32_maxmin_seq.sv
// tb/tb_fp32_maxmin_seq.sv - randomized bench with a real-arithmetic argmax/argmin model
module tb_fp32_maxmin_seq;

   localparam int LEN_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             i_start = 1'b0;
   logic             i_mode = 1'b0;
   logic [LEN_W-1:0] i_len = '0;
   logic             i_valid = 1'b0;
   logic [31:0]      i_data = '0;
   logic             o_ready, o_busy, o_done, o_nan_err;
   logic [31:0]      o_result;
   logic [LEN_W-1:0] o_index;

   fp32_maxmin_seq #(.LEN_W(LEN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_start   (i_start),
      .i_mode    (i_mode),
      .i_len     (i_len),
      .i_valid   (i_valid),
      .i_data    (i_data),
      .o_ready   (o_ready),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_result  (o_result),
      .o_index   (o_index),
      .o_nan_err (o_nan_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      int          idx;
      bit          nan;
   } exp_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] stim[$];
   exp_t        exp_q[$];
   exp_t        last_exp = '{32'h0, 0, 1'b0};
   logic [31:0] pool[9] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                            32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 32'h0000_0001,
                            32'h8000_0001};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic bit f_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 0);
   endfunction

   function automatic real to_real(input logic [31:0] x);
      real v;
      int  e;
      e = int'(x[30:23]);
      if (e == 255)    v = 1.0e300;
      else if (e == 0) v = real'(x[22:0]) * (2.0 ** (-149));
      else             v = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
      return x[31] ? -v : v;
   endfunction

   function automatic bit gt(input logic [31:0] a, input logic [31:0] b);
      if (a[30:0] == 0 && b[30:0] == 0) return !a[31] && b[31];
      return to_real(a) > to_real(b);
   endfunction

   // Reduction over stim[0..len-1]: strict compare keeps the earliest winner; any NaN poisons the result.
   function automatic void model(input bit mode, input int len,
                                 output logic [31:0] res, output int idx, output bit nan);
      logic [31:0] best;
      best = 32'h0;
      idx  = 0;
      nan  = 1'b0;
      for (int i = 0; i < len; i++) begin
         if (f_nan(stim[i])) nan = 1'b1;
         else if (i == 0) best = stim[i];
         else if (!f_nan(best) && (mode ? gt(best, stim[i]) : gt(stim[i], best))) begin
            best = stim[i];
            idx  = i;
         end
         if (i == 0) best = stim[0];
      end
      res = nan ? 32'hFFFF_FFFF : best;
   endfunction

   function automatic logic [31:0] rand_fp();
      int          r;
      logic [31:0] x;
      r = $urandom_range(0, 29);
      if (r == 0) return 32'h7FC0_0000 | 32'($urandom_range(0, 255));
      if (r < 10) return pool[r-1];
      x = $urandom;
      if (r < 24) x[30:23] = 8'($urandom_range(124, 130));
      if (r < 18) x[22:0]  = {x[22:20], 20'h0};
      if (x[30:23] == 8'hFF) x[22:0] = '0;
      return x;
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (o_done) begin
         if (exp_q.size() == 0) begin
            check("spurious_done", 32'(o_done), 32'h0);
         end else begin
            e = exp_q.pop_front();
            check("done_result", o_result, e.res);
            check("done_nan_err", 32'(o_nan_err), 32'(e.nan));
            if (!e.nan) check("done_index", 32'(o_index), e.idx);
            last_exp = e;
         end
      end else if (!o_busy) begin
         check("idle_ready", 32'(o_ready), 32'h0);
         check("idle_hold_result", o_result, last_exp.res);
         check("idle_hold_nan_err", 32'(o_nan_err), 32'(last_exp.nan));
         if (!last_exp.nan) check("idle_hold_index", 32'(o_index), last_exp.idx);
      end
   end

   // Called at a negedge with DUT idle; returns at the negedge after o_done (or after an abort).
   task automatic run_seq(input bit mode, input int len, input int abort_after, input bit poke);
      exp_t e;
      logic [31:0] r;
      int          ix;
      bit          nn;
      int          w;
      int          lat;
      if (abort_after < 0) begin
         model(mode, len, r, ix, nn);
         e = '{r, ix, nn};
         exp_q.push_back(e);
      end
      i_start = 1'b1;
      i_mode  = mode;
      i_len   = LEN_W'(len);
      @(negedge clk);
      i_start = 1'b0;
      check("ready_after_start", 32'(o_ready), 32'(len != 0));
      lat = 1;
      for (int k = 0; k < len; k++) begin
         repeat ($urandom_range(0, 2)) begin
            i_valid = 1'b0;
            @(negedge clk);
         end
         if (poke && k == 1) begin
            i_start = 1'b1;
            i_len   = '0;
            i_mode  = ~mode;
         end
         i_valid = 1'b1;
         i_data  = stim[k];
         w = 0;
         while (!o_ready && w < 20) begin
            @(negedge clk);
            i_start = 1'b0;
            w++;
         end
         if (!o_ready) begin
            check("ready_timeout", 32'(o_ready), 32'h1);
            i_valid = 1'b0;
            return;
         end
         @(negedge clk);
         i_start = 1'b0;
         i_valid = 1'b0;
         i_data  = $urandom;
         if (abort_after == k + 1) begin
            @(posedge clk);
            #2;
            rst      = 1'b1;
            last_exp = '{32'h0, 0, 1'b0};
            #1;
            check("reset_busy", 32'(o_busy), 32'h0);
            check("reset_ready", 32'(o_ready), 32'h0);
            check("reset_done", 32'(o_done), 32'h0);
            repeat (2) @(posedge clk);
            #2 rst = 1'b0;
            @(negedge clk);
            return;
         end
      end
      while (!o_done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("done_latency", 32'(lat), (len >= 2) ? 32'd2 : 32'd1);
      @(negedge clk);
   endtask

   task automatic pin(input string name, input bit mode, input logic [31:0] res_r,
                      input int idx_r, input bit nan_r);
      logic [31:0] r;
      int          ix;
      bit          nn;
      model(mode, stim.size(), r, ix, nn);
      check({name, "_model_result"}, r, res_r);
      check({name, "_model_nan"}, 32'(nn), 32'(nan_r));
      if (!nan_r) check({name, "_model_index"}, 32'(ix), idx_r);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(o_ready), 32'h0);
      check("rst_busy", 32'(o_busy), 32'h0);
      check("rst_done", 32'(o_done), 32'h0);
      check("rst_nan_err", 32'(o_nan_err), 32'h0);
      check("rst_result", o_result, 32'h0);
      check("rst_index", 32'(o_index), 32'h0);
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);

      stim = {32'h3F80_0000, 32'hC000_0000, 32'h4060_0000, 32'h3F00_0000};
      pin("max4", 1'b0, 32'h4060_0000, 2, 1'b0);
      run_seq(1'b0, 4, -1, 1'b0);
      pin("min4", 1'b1, 32'hC000_0000, 1, 1'b0);
      run_seq(1'b1, 4, -1, 1'b0);

      stim = {32'h4000_0000, 32'h4000_0000};
      pin("tie", 1'b0, 32'h4000_0000, 0, 1'b0);
      run_seq(1'b0, 2, -1, 1'b0);
      stim = {32'h8000_0000, 32'h0000_0000};
      pin("szero", 1'b0, 32'h0000_0000, 1, 1'b0);
      run_seq(1'b0, 2, -1, 1'b0);

      stim = {32'h3F80_0000, 32'h7FC0_0000, 32'h4000_0000};
      pin("nan_mid", 1'b0, 32'hFFFF_FFFF, 0, 1'b1);
      run_seq(1'b0, 3, -1, 1'b0);
      stim = {32'h7FC0_0000, 32'h3F80_0000, 32'h4000_0000};
      pin("nan_first", 1'b0, 32'hFFFF_FFFF, 0, 1'b1);
      run_seq(1'b0, 3, -1, 1'b0);

      stim = {};
      pin("len0", 1'b0, 32'h0, 0, 1'b0);
      run_seq(1'b0, 0, -1, 1'b0);
      stim = {32'hBF80_0000};
      pin("len1", 1'b1, 32'hBF80_0000, 0, 1'b0);
      run_seq(1'b1, 1, -1, 1'b0);

      stim = {32'h3F80_0000, 32'h4100_0000, 32'hC100_0000, 32'h3F00_0000, 32'h4100_0000};
      pin("poke", 1'b0, 32'h4100_0000, 1, 1'b0);
      run_seq(1'b0, 5, -1, 1'b1);

      stim = {32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
      run_seq(1'b0, 4, 2, 1'b0);
      stim = {32'h4080_0000, 32'hC080_0000};
      pin("after_rst", 1'b1, 32'hC080_0000, 1, 1'b0);
      run_seq(1'b1, 2, -1, 1'b0);

      for (int n = 0; n < 60; n++) begin
         int len;
         bit mode;
         len  = $urandom_range(0, 9);
         mode = 1'($urandom_range(0, 1));
         stim.delete();
         for (int j = 0; j < len; j++) stim.push_back(rand_fp());
         run_seq(mode, len, -1, (len >= 3) && ($urandom_range(0, 3) == 0));
      end

      repeat (3) @(negedge clk);
      check("pending_results", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
